demux12_ctrl: RTL and testbench
===============================

Name: demux12_ctrl

Overview:
- Scheduler that feeds the 1:2 class/destination demux from a single upstream FIFO.
- Pops one 10-bit word at a time and decodes the destination bit.
- Holds the word until the target downstream FIFO is not almost-full, then issues a single-cycle valid pulse with a matching select to the demux.
- Keeps saturating per-destination forwarded-word counters for the switch status logic.

Parameters:
DATA_WIDTH, 10, word width on the FIFO and demux interfaces
DEST_BIT, 8, bit index of the word that selects the destination (0 -> out0, 1 -> out1)
CNT_WIDTH, 8, width of each forwarded-word counter

Ports:
clk  input  1  system clock, all state changes on the rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs immediately
enable  input  1  allows new pops; sampled only in IDLE and at ROUTE exit
fifo_empty  input  1  upstream FIFO empty flag
fifo_data  input  DATA_WIDTH  upstream FIFO read data, valid one cycle after the pop is sampled
fifo_pop  output  1  upstream FIFO pop request, registered
almost_full_0  input  1  downstream FIFO 0 almost-full; blocks forwarding to destination 0
almost_full_1  input  1  downstream FIFO 1 almost-full; blocks forwarding to destination 1
demux_in  output  DATA_WIDTH  word to the demux data input, registered
demux_valid  output  1  one-cycle valid pulse to the demux
demux_select  output  1  demux select, equal to the held word's DEST_BIT
stall  output  1  high while the held word is blocked by almost-full
busy  output  1  high in any state other than IDLE
count_0  output  CNT_WIDTH  words forwarded to destination 0, saturating
count_1  output  CNT_WIDTH  words forwarded to destination 1, saturating

Behaviour:
- Reset (asynchronous, no clock needed):
  - state=IDLE.
  - fifo_pop, demux_valid, demux_select, stall, busy = 0.
  - demux_in = 0, hold register = 0, count_0 = count_1 = 0.
  - Reset mid-operation discards the word in flight. A pop already sampled by the FIFO is lost; this is accepted.
- All outputs are registered. States are IDLE, POP, LATCH, ROUTE.
- IDLE:
  - If enable=1 and fifo_empty=0: fifo_pop<=1, go to POP.
  - Otherwise stay in IDLE.
- POP:
  - fifo_pop is high for exactly this one cycle; the FIFO samples it at the closing edge.
  - At that edge: fifo_pop<=0, go to LATCH.
- LATCH:
  - fifo_data is valid during this cycle.
  - At the closing edge: hold<=fifo_data, go to ROUTE.
- ROUTE, with dest = hold[DEST_BIT]:
  - If almost_full_dest=0 at the edge:
    - demux_in<=hold, demux_select<=dest, demux_valid<=1 for one cycle, stall<=0.
    - count_dest increments, unless it is already all-ones (saturates).
    - If enable=1 and fifo_empty=0, go directly to POP with fifo_pop<=1 (back-to-back). Otherwise go to IDLE.
  - If almost_full_dest=1: stall<=1, stay in ROUTE, hold unchanged.
  - The almost-full flag of the other destination is ignored; head-of-line blocking is intended.
- demux_valid is 0 in every cycle except the one after a ROUTE exit.
- demux_in and demux_select keep their last values when demux_valid=0.
- Throughput: one word per 3 cycles sustained (POP, LATCH, ROUTE).
- Latency: 3 edges from fifo_pop assertion to demux_valid assertion when there is no stall.
- enable deasserted mid-word does not abort the word; it only prevents the next pop.
- fifo_pop is never asserted while fifo_empty=1, and never in LATCH or ROUTE-stall.
- busy = (state != IDLE), registered with the state.
- Counter width rules: counters are CNT_WIDTH bits and saturate at 2^CNT_WIDTH-1. They do not wrap, and they clear only on reset.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle with the FSM in ROUTE. All outputs must go to 0 immediately, and after release the FSM must sit in IDLE with busy=0.
- Single word to destination 0:
  - Stimulus: FIFO holds 10'h055 (bit8=0), enable=1, no almost-full.
  - Response: fifo_pop pulses one cycle; 3 edges later demux_valid=1 with demux_in=10'h055 and demux_select=0; count_0=1.
- Back-to-back to both destinations:
  - Stimulus: FIFO holds 10'h1AA, then 10'h033.
  - Response: pulses 3 cycles apart, with select=1 then select=0; count_1=1, count_0=1; fifo_pop never high while fifo_empty=1.
- Backpressure:
  - Stimulus: word 10'h1F0 with almost_full_1=1 for 5 cycles and almost_full_0=1 throughout.
  - Response: stall=1 for 5 cycles, no demux_valid and no pop during the stall; demux_valid fires the cycle after almost_full_1 falls; almost_full_0 has no effect.
- Enable drop mid-word: deassert enable during LATCH. The word must still be forwarded, then the FSM returns to IDLE with no further fifo_pop despite fifo_empty=0.
- Saturation: with CNT_WIDTH=2, forward 5 words to destination 0. count_0 sequence must be 1, 2, 3, 3, 3, and count_1 must stay 0.

Source files
------------

// File: rtl/demux12_ctrl.sv
// demux12_ctrl: pops words from a single upstream FIFO, holds each word until
// its destination FIFO has room, then presents it to the 1:2 demux with a
// one-cycle valid pulse. Keeps saturating forwarded-word counters per output.
module demux12_ctrl #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned DEST_BIT   = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    input  logic                  almost_full_0,
    input  logic                  almost_full_1,
    output logic [DATA_WIDTH-1:0] demux_in,
    output logic                  demux_valid,
    output logic                  demux_select,
    output logic                  stall,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  count_0,
    output logic [CNT_WIDTH-1:0]  count_1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        LATCH = 2'd2,
        ROUTE = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hold;
    logic                  route_dest;
    logic                  route_blocked;
    logic                  can_pop;

    // Destination decode of the held word and the pop qualifier
    always_comb begin
        route_dest    = hold[DEST_BIT];
        route_blocked = route_dest ? almost_full_1 : almost_full_0;
        can_pop       = enable && !fifo_empty;
    end

    // Sequencer: IDLE -> POP -> LATCH -> ROUTE, with back-to-back re-entry to POP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hold         <= '0;
            fifo_pop     <= 1'b0;
            demux_in     <= '0;
            demux_valid  <= 1'b0;
            demux_select <= 1'b0;
            stall        <= 1'b0;
            busy         <= 1'b0;
            count_0      <= '0;
            count_1      <= '0;
        end else begin
            demux_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_pop) begin
                        fifo_pop <= 1'b1;
                        busy     <= 1'b1;
                        state    <= POP;
                    end
                end
                POP: begin
                    fifo_pop <= 1'b0;
                    state    <= LATCH;
                end
                LATCH: begin
                    hold  <= fifo_data;
                    state <= ROUTE;
                end
                ROUTE: begin
                    if (route_blocked) begin
                        stall <= 1'b1;
                    end else begin
                        demux_in     <= hold;
                        demux_select <= route_dest;
                        demux_valid  <= 1'b1;
                        stall        <= 1'b0;
                        if (route_dest) begin
                            if (!(&count_1)) count_1 <= count_1 + CNT_WIDTH'(1);
                        end else begin
                            if (!(&count_0)) count_0 <= count_0 + CNT_WIDTH'(1);
                        end
                        if (can_pop) begin
                            fifo_pop <= 1'b1;
                            state    <= POP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    fifo_pop <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux12_ctrl.sv
// Directed bench for demux12_ctrl with a small upstream FIFO model.
module tb_demux12_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [9:0] fifo_data;
    logic       fifo_pop;
    logic       almost_full_0;
    logic       almost_full_1;
    logic [9:0] demux_in;
    logic       demux_valid;
    logic       demux_select;
    logic       stall;
    logic       busy;
    logic [7:0] count_0;
    logic [7:0] count_1;

    logic       s_fifo_pop;
    logic [9:0] s_demux_in;
    logic       s_demux_valid;
    logic       s_demux_select;
    logic       s_stall;
    logic       s_busy;
    logic [1:0] s_count_0;
    logic [1:0] s_count_1;

    int checks = 0;
    int errors = 0;
    int pop_empty_cnt = 0;

    logic [9:0] mem [64];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    demux12_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .almost_full_0(almost_full_0), .almost_full_1(almost_full_1),
        .demux_in(demux_in), .demux_valid(demux_valid), .demux_select(demux_select),
        .stall(stall), .busy(busy), .count_0(count_0), .count_1(count_1)
    );

    demux12_ctrl #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_pop(s_fifo_pop),
        .almost_full_0(almost_full_0), .almost_full_1(almost_full_1),
        .demux_in(s_demux_in), .demux_valid(s_demux_valid), .demux_select(s_demux_select),
        .stall(s_stall), .busy(s_busy), .count_0(s_count_0), .count_1(s_count_1)
    );

    // Upstream FIFO: data appears the cycle after a sampled pop
    always @(posedge clk) begin
        if (fifo_pop && fifo_empty) pop_empty_cnt <= pop_empty_cnt + 1;
        if (fifo_pop && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 6'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic do_reset();
        enable = 1'b0; almost_full_0 = 1'b0; almost_full_1 = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_values();
        enable = 1'b0; almost_full_0 = 1'b0; almost_full_1 = 1'b0; fifo_data = '0;
        reset = 1'b1;
        #1;
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL por_pop got %b want 0", fifo_pop); end
        checks++; if (demux_valid !== 1'b0) begin errors++; $display("FAIL por_valid got %b want 0", demux_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL por_busy got %b want 0", busy); end
        checks++; if (demux_in !== 10'h000) begin errors++; $display("FAIL por_in got %h want 000", demux_in); end
        checks++; if (count_0 !== 8'd0 || count_1 !== 8'd0) begin errors++; $display("FAIL por_counts got %0d/%0d want 0/0", count_0, count_1); end
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL por_idle busy=%b pop=%b want 0/0", busy, fifo_pop); end
    endtask

    task automatic test_single_dest0();
        do_reset();
        push(10'h055);
        enable = 1'b1;
        tick();
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL single_pop got %b want 1", fifo_pop); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        tick();
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL single_pop_one_cycle got %b want 0", fifo_pop); end
        tick();
        checks++; if (demux_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", demux_valid); end
        tick();
        checks++; if (demux_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", demux_valid); end
        checks++; if (demux_in !== 10'h055) begin errors++; $display("FAIL single_data got %h want 055", demux_in); end
        checks++; if (demux_select !== 1'b0) begin errors++; $display("FAIL single_sel got %b want 0", demux_select); end
        checks++; if (count_0 !== 8'd1 || count_1 !== 8'd0) begin errors++; $display("FAIL single_counts got %0d/%0d want 1/0", count_0, count_1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
        tick();
        checks++; if (demux_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse got %b want 0", demux_valid); end
        checks++; if (demux_in !== 10'h055) begin errors++; $display("FAIL single_data_hold got %h want 055", demux_in); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(10'h1AA);
        push(10'h033);
        enable = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (demux_valid !== 1'b1 || demux_in !== 10'h1AA) begin errors++; $display("FAIL b2b_first valid=%b data=%h want 1/1aa", demux_valid, demux_in); end
        checks++; if (demux_select !== 1'b1) begin errors++; $display("FAIL b2b_first_sel got %b want 1", demux_select); end
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL b2b_repop got %b want 1", fifo_pop); end
        tick();
        checks++; if (demux_valid !== 1'b0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL b2b_gap1 valid=%b pop=%b want 0/0", demux_valid, fifo_pop); end
        tick();
        checks++; if (demux_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap2 got %b want 0", demux_valid); end
        tick();
        checks++; if (demux_valid !== 1'b1 || demux_in !== 10'h033) begin errors++; $display("FAIL b2b_second valid=%b data=%h want 1/033", demux_valid, demux_in); end
        checks++; if (demux_select !== 1'b0) begin errors++; $display("FAIL b2b_second_sel got %b want 0", demux_select); end
        checks++; if (count_0 !== 8'd1 || count_1 !== 8'd1) begin errors++; $display("FAIL b2b_counts got %0d/%0d want 1/1", count_0, count_1); end
        checks++; if (fifo_pop !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end pop=%b busy=%b want 0/0", fifo_pop, busy); end
        checks++; if (pop_empty_cnt !== 0) begin errors++; $display("FAIL b2b_pop_while_empty got %0d want 0", pop_empty_cnt); end
    endtask

    task automatic test_reset_mid();
        push(10'h155);
        almost_full_1 = 1'b1;
        enable = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (stall !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre stall=%b busy=%b want 1/1", stall, busy); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async stall=%b busy=%b want 0/0", stall, busy); end
        checks++; if (demux_in !== 10'h000 || demux_select !== 1'b0) begin errors++; $display("FAIL rst_async_data in=%h sel=%b want 000/0", demux_in, demux_select); end
        checks++; if (count_0 !== 8'd0 || count_1 !== 8'd0) begin errors++; $display("FAIL rst_async_counts got %0d/%0d want 0/0", count_0, count_1); end
        checks++; if (fifo_pop !== 1'b0 || demux_valid !== 1'b0) begin errors++; $display("FAIL rst_async_pulses pop=%b valid=%b want 0/0", fifo_pop, demux_valid); end
        enable = 1'b0; almost_full_1 = 1'b0;
        #2;
        reset = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0 || demux_valid !== 1'b0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL rst_after busy=%b valid=%b pop=%b want 0/0/0", busy, demux_valid, fifo_pop); end
    endtask

    task automatic test_backpressure();
        do_reset();
        almost_full_0 = 1'b1;
        almost_full_1 = 1'b1;
        push(10'h1F0);
        push(10'h0AB);
        enable = 1'b1;
        tick(); tick(); tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bp_prestall got %b want 0", stall); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (stall !== 1'b1 || demux_valid !== 1'b0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL bp_stall%0d stall=%b valid=%b pop=%b want 1/0/0", i, stall, demux_valid, fifo_pop); end
        end
        almost_full_1 = 1'b0;
        tick();
        checks++; if (demux_valid !== 1'b1 || demux_in !== 10'h1F0 || demux_select !== 1'b1) begin errors++; $display("FAIL bp_release valid=%b data=%h sel=%b want 1/1f0/1", demux_valid, demux_in, demux_select); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bp_stall_clear got %b want 0", stall); end
        checks++; if (count_1 !== 8'd1 || count_0 !== 8'd0) begin errors++; $display("FAIL bp_counts got %0d/%0d want 0/1", count_0, count_1); end
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL bp_repop got %b want 1", fifo_pop); end
        tick();
    endtask

    task automatic test_enable_drop();
        do_reset();
        push(10'h0C3);
        push(10'h044);
        enable = 1'b1;
        tick(); tick();
        enable = 1'b0;
        tick(); tick();
        checks++; if (demux_valid !== 1'b1 || demux_in !== 10'h0C3 || demux_select !== 1'b0) begin errors++; $display("FAIL en_fwd valid=%b data=%h sel=%b want 1/0c3/0", demux_valid, demux_in, demux_select); end
        checks++; if (fifo_pop !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL en_stop pop=%b busy=%b want 0/0", fifo_pop, busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fifo_pop !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL en_idle%0d pop=%b busy=%b want 0/0", i, fifo_pop, busy); end
        end
        enable = 1'b1;
        tick();
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL en_resume got %b want 1", fifo_pop); end
        enable = 1'b0;
        tick(); tick(); tick();
        checks++; if (demux_valid !== 1'b1 || demux_in !== 10'h044) begin errors++; $display("FAIL en_second valid=%b data=%h want 1/044", demux_valid, demux_in); end
        checks++; if (count_0 !== 8'd2) begin errors++; $display("FAIL en_count got %0d want 2", count_0); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat [5];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 1; i <= 5; i++) push(10'(i));
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            repeat ((i == 0) ? 4 : 3) tick();
            checks++; if (s_demux_valid !== 1'b1) begin errors++; $display("FAIL sat_valid%0d got %b want 1", i, s_demux_valid); end
            checks++; if (s_count_0 !== exp_sat[i]) begin errors++; $display("FAIL sat_count0_%0d got %0d want %0d", i, s_count_0, exp_sat[i]); end
            checks++; if (s_count_1 !== 2'd0) begin errors++; $display("FAIL sat_count1_%0d got %0d want 0", i, s_count_1); end
            checks++; if (count_0 !== 8'(i + 1)) begin errors++; $display("FAIL wide_count0_%0d got %0d want %0d", i, count_0, i + 1); end
        end
        enable = 1'b0;
        tick();
        checks++; if (s_busy !== 1'b0 || s_count_0 !== 2'd3) begin errors++; $display("FAIL sat_end busy=%b count=%0d want 0/3", s_busy, s_count_0); end
    endtask

    initial begin
        test_reset_values();
        test_single_dest0();
        test_back_to_back();
        test_reset_mid();
        test_backpressure();
        test_enable_drop();
        test_saturation();
        checks++; if (pop_empty_cnt !== 0) begin errors++; $display("FAIL pop_while_empty got %0d want 0", pop_empty_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
